// File: rtl/reflex_trigger.sv
// reflex_trigger: decides when a reflex correction fires from per-line symmetry metrics.
// A drift excursion must persist for DEBOUNCE consecutive lines, a jerk excursion fires
// at once, and every fire is followed by a cooldown of COOLDOWN_LINES metric strobes.
// Each fire emits a one-cycle pulse, a direction bit and a saturated correction command.
// Optional feature macro: SPREAD_CHECK_EN (spread excursion OR'd into the drift debounce).
module reflex_trigger #(
  parameter int DRIFT_W        = 24,
  parameter int SPREAD_W       = 32,
  parameter int DEBOUNCE       = 3,
  parameter int COOLDOWN_LINES = 8,
  parameter int GAIN_SHIFT     = 6,
  parameter int CMD_W          = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       metric_valid,
  input  logic signed [DRIFT_W-1:0]  drift_metric,
  input  logic signed [SPREAD_W-1:0] spread_metric,
  input  logic signed [DRIFT_W-1:0]  sudden_change,
  input  logic        [DRIFT_W-1:0]  drift_thresh,
  input  logic        [DRIFT_W-1:0]  jerk_thresh,
  input  logic        [SPREAD_W-1:0] spread_thresh,
  output logic                       reflex_fire,
  output logic                       reflex_dir,
  output logic signed [CMD_W-1:0]    correction_cmd,
  output logic        [7:0]          fire_count,
  output logic        [2:0]          state_o
);

  // Magnitudes carry one extra bit so the most negative input has a representable |x|.
  localparam int MAG_W = DRIFT_W + 1;
  localparam int SMAG_W = SPREAD_W + 1;

  // The saturation compare runs at whichever is wider: the negated drift or the command.
  localparam int EXT_W = (MAG_W > CMD_W) ? MAG_W : CMD_W;

  localparam logic signed [EXT_W-1:0] CMD_MAX =
    {{(EXT_W - CMD_W + 1){1'b0}}, {(CMD_W - 1){1'b1}}};
  localparam logic signed [EXT_W-1:0] CMD_MIN =
    {{(EXT_W - CMD_W + 1){1'b1}}, {(CMD_W - 1){1'b0}}};

  // Counter widths are sized to hold their terminal value exactly.
  localparam int DEB_W = $clog2(DEBOUNCE + 1);
  localparam int CD_W  = $clog2(COOLDOWN_LINES + 1);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE);
  localparam logic [CD_W-1:0]  CD_LAST  = CD_W'(COOLDOWN_LINES);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MONITOR  = 3'd1,
    PENDING  = 3'd2,
    FIRE     = 3'd3,
    COOLDOWN = 3'd4
  } state_t;

  state_t state;
  logic [DEB_W-1:0] deb_cnt;
  logic [CD_W-1:0]  cd_cnt;

  logic signed [MAG_W-1:0] drift_ext;
  logic signed [MAG_W-1:0] sudden_ext;
  logic        [MAG_W-1:0] drift_mag;
  logic        [MAG_W-1:0] sudden_mag;
  logic signed [MAG_W-1:0] drift_shr;
  logic signed [MAG_W-1:0] drift_neg;
  logic signed [EXT_W-1:0] neg_ext;
  logic signed [CMD_W-1:0] cmd_sat;

  logic drift_hit;
  logic jerk_hit;
  logic level_hit;
  logic [DEB_W-1:0] deb_next;
  logic [CD_W-1:0]  cd_next;
  logic fire_now;

  // Sign-extend the metrics and form strict-threshold hit flags from their magnitudes.
  always_comb begin
    drift_ext  = {drift_metric[DRIFT_W-1], drift_metric};
    sudden_ext = {sudden_change[DRIFT_W-1], sudden_change};
    drift_mag  = drift_ext[MAG_W-1]  ? (~drift_ext  + MAG_W'(1)) : drift_ext;
    sudden_mag = sudden_ext[MAG_W-1] ? (~sudden_ext + MAG_W'(1)) : sudden_ext;
    drift_hit  = drift_mag  > {1'b0, drift_thresh};
    jerk_hit   = sudden_mag > {1'b0, jerk_thresh};
  end

`ifdef SPREAD_CHECK_EN
  logic signed [SMAG_W-1:0] spread_ext;
  logic        [SMAG_W-1:0] spread_mag;
  logic                     spread_hit;

  // A spread excursion counts as a level hit and shares the drift debounce.
  always_comb begin
    spread_ext = {spread_metric[SPREAD_W-1], spread_metric};
    spread_mag = spread_ext[SMAG_W-1] ? (~spread_ext + SMAG_W'(1)) : spread_ext;
    spread_hit = spread_mag > {1'b0, spread_thresh};
    level_hit  = drift_hit | spread_hit;
  end
`else
  logic unused_spread;

  // Without the spread check only drift feeds the debounce; spread inputs are dropped.
  always_comb begin
    level_hit     = drift_hit;
    unused_spread = ^{spread_metric, spread_thresh, SMAG_W[0]};
  end
`endif

  // Correction is the negated, scaled drift, clamped into the signed command range.
  always_comb begin
    drift_shr = drift_ext >>> GAIN_SHIFT;
    drift_neg = -drift_shr;
    neg_ext   = EXT_W'(drift_neg);
    if (neg_ext > CMD_MAX) begin
      cmd_sat = CMD_MAX[CMD_W-1:0];
    end else if (neg_ext < CMD_MIN) begin
      cmd_sat = CMD_MIN[CMD_W-1:0];
    end else begin
      cmd_sat = neg_ext[CMD_W-1:0];
    end
  end

  // Decide whether this cycle's strobe qualifies a fire; jerk always wins over debounce.
  always_comb begin
    deb_next = deb_cnt + DEB_W'(1);
    cd_next  = cd_cnt + CD_W'(1);
    fire_now = 1'b0;
    if (enable && metric_valid) begin
      if (state == MONITOR) begin
        fire_now = jerk_hit || (level_hit && (DEBOUNCE == 1));
      end else if (state == PENDING) begin
        fire_now = jerk_hit || (level_hit && (deb_next == DEB_LAST));
      end
    end
  end

  // Main controller: enable=0 dominates, otherwise strobe-driven state progression.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      deb_cnt     <= '0;
      cd_cnt      <= '0;
      reflex_fire <= 1'b0;
    end else if (!enable) begin
      state       <= IDLE;
      deb_cnt     <= '0;
      cd_cnt      <= '0;
      reflex_fire <= 1'b0;
    end else if (fire_now) begin
      state       <= FIRE;
      deb_cnt     <= '0;
      cd_cnt      <= '0;
      reflex_fire <= 1'b1;
    end else begin
      reflex_fire <= 1'b0;
      case (state)
        IDLE: begin
          state <= MONITOR;
        end
        MONITOR: begin
          if (metric_valid && level_hit) begin
            state   <= PENDING;
            deb_cnt <= DEB_W'(1);
          end
        end
        PENDING: begin
          if (metric_valid) begin
            if (level_hit) begin
              deb_cnt <= deb_next;
            end else begin
              state   <= MONITOR;
              deb_cnt <= '0;
            end
          end
        end
        FIRE: begin
          state  <= COOLDOWN;
          cd_cnt <= '0;
        end
        COOLDOWN: begin
          if (metric_valid) begin
            if (cd_next == CD_LAST) begin
              state  <= MONITOR;
              cd_cnt <= '0;
            end else begin
              cd_cnt <= cd_next;
            end
          end
        end
        default: begin
          state   <= IDLE;
          deb_cnt <= '0;
          cd_cnt  <= '0;
        end
      endcase
    end
  end

  // Capture direction and command from the triggering line; count fires up to 255.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reflex_dir     <= 1'b0;
      correction_cmd <= '0;
      fire_count     <= '0;
    end else if (fire_now) begin
      reflex_dir     <= ~drift_metric[DRIFT_W-1];
      correction_cmd <= cmd_sat;
      if (fire_count != 8'hFF) begin
        fire_count <= fire_count + 8'd1;
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_reflex_trigger.sv
// tb_reflex_trigger: directed scenarios plus randomized traffic for reflex_trigger,
// compared every cycle against a line-counting behavioural model of the trigger rules.
module tb_reflex_trigger;

  localparam int DW  = 24;
  localparam int SW  = 32;
  localparam int DEB = 3;
  localparam int CDL = 8;
  localparam int GS  = 6;
  localparam int CW  = 12;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 enable;
  logic                 metric_valid;
  logic signed [DW-1:0] drift_metric;
  logic signed [SW-1:0] spread_metric;
  logic signed [DW-1:0] sudden_change;
  logic        [DW-1:0] drift_thresh;
  logic        [DW-1:0] jerk_thresh;
  logic        [SW-1:0] spread_thresh;
  logic                 reflex_fire;
  logic                 reflex_dir;
  logic signed [CW-1:0] correction_cmd;
  logic        [7:0]    fire_count;
  logic        [2:0]    state_o;

  int vectors = 0;
  int miscompares = 0;

  // Model: phase 0..4 named as the observable state code, plus line counters.
  int     m_phase;
  int     m_streak;
  int     m_cd_left;
  bit     m_fire;
  bit     m_dir;
  longint m_cmd;
  int     m_count;

  reflex_trigger #(
    .DRIFT_W(DW), .SPREAD_W(SW), .DEBOUNCE(DEB), .COOLDOWN_LINES(CDL),
    .GAIN_SHIFT(GS), .CMD_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .metric_valid(metric_valid),
    .drift_metric(drift_metric), .spread_metric(spread_metric),
    .sudden_change(sudden_change), .drift_thresh(drift_thresh),
    .jerk_thresh(jerk_thresh), .spread_thresh(spread_thresh),
    .reflex_fire(reflex_fire), .reflex_dir(reflex_dir),
    .correction_cmd(correction_cmd), .fire_count(fire_count), .state_o(state_o)
  );

  always #5 clk = ~clk;

  function automatic longint absl(input longint x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic longint expected_cmd(input longint d);
    longint v;
    longint hi;
    v  = -(d >>> GS);
    hi = (longint'(1) <<< (CW - 1)) - 1;
    if (v > hi) v = hi;
    if (v < -hi - 1) v = -hi - 1;
    return v;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_streak = 0; m_cd_left = 0;
    m_fire = 0; m_dir = 0; m_cmd = 0; m_count = 0;
  endtask

  // One clock edge of the trigger rules, read from the inputs present at that edge.
  task automatic model_tick();
    bit     go;
    bit     lvl;
    bit     jerk;
    longint d;
    go = 0;
    d  = longint'(drift_metric);
    if (rst) begin
      model_reset();
    end else if (!enable) begin
      m_phase = 0; m_streak = 0; m_cd_left = 0; m_fire = 0;
    end else begin
      m_fire = 0;
      lvl  = absl(d) > longint'(drift_thresh);
`ifdef SPREAD_CHECK_EN
      lvl  = lvl || (absl(longint'(spread_metric)) > longint'(spread_thresh));
`endif
      jerk = absl(longint'(sudden_change)) > longint'(jerk_thresh);
      if (m_phase == 0) begin
        m_phase = 1;
      end else if (m_phase == 1 || m_phase == 2) begin
        if (metric_valid) begin
          if (jerk) begin
            go = 1;
          end else if (lvl) begin
            m_streak++;
            if (m_streak >= DEB) go = 1;
            else m_phase = 2;
          end else begin
            m_streak = 0;
            m_phase = 1;
          end
        end
      end else if (m_phase == 3) begin
        m_phase = 4;
        m_cd_left = CDL;
      end else begin
        if (metric_valid) begin
          m_cd_left--;
          if (m_cd_left == 0) m_phase = 1;
        end
      end
      if (go) begin
        m_phase = 3; m_streak = 0; m_fire = 1;
        m_dir = (d >= 0);
        m_cmd = expected_cmd(d);
        if (m_count < 255) m_count++;
      end
    end
  endtask

  task automatic cmp(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  task automatic check_outputs();
    cmp("state", longint'(state_o), longint'(m_phase));
    cmp("fire", longint'(reflex_fire), longint'(m_fire));
    cmp("dir", longint'(reflex_dir), longint'(m_dir));
    cmp("cmd", longint'(correction_cmd), m_cmd);
    cmp("count", longint'(fire_count), longint'(m_count));
  endtask

  task automatic step(input bit r, input bit en, input bit mv,
                      input longint d, input longint s);
    @(negedge clk);
    rst = r;
    enable = en;
    metric_valid = mv;
    drift_metric = DW'(d);
    sudden_change = DW'(s);
    spread_metric = SW'($urandom);
    @(posedge clk);
    model_tick();
    #1;
    check_outputs();
  endtask

  task automatic line(input longint d, input longint s);
    step(1'b0, 1'b1, 1'b1, d, s);
  endtask

  task automatic idle_cycle();
    step(1'b0, 1'b1, 1'b0, 0, 0);
  endtask

  initial begin
    longint span;
    longint d;
    longint s;
    int pick;

    rst = 1'b1; enable = 1'b0; metric_valid = 1'b0;
    drift_metric = '0; sudden_change = '0; spread_metric = '0;
    drift_thresh = DW'(100); jerk_thresh = DW'(200); spread_thresh = SW'(1000);
    model_reset();
    #12;
    cmp("reset_state", longint'(state_o), 0);
    cmp("reset_count", longint'(fire_count), 0);
    cmp("reset_cmd", longint'(correction_cmd), 0);

    step(1'b0, 1'b0, 1'b0, 0, 0);
    idle_cycle();
    cmp("lit_monitor", longint'(state_o), 1);

    // Three consecutive drift lines fire one cycle after the third strobe.
    line(150, 0);
    cmp("lit_pending", longint'(state_o), 2);
    line(150, 0);
    cmp("lit_no_early_fire", longint'(reflex_fire), 0);
    line(150, 0);
    cmp("lit_t1_fire", longint'(reflex_fire), 1);
    cmp("lit_t1_dir", longint'(reflex_dir), 1);
    cmp("lit_t1_cmd", longint'(correction_cmd), -2);
    cmp("lit_t1_count", longint'(fire_count), 1);

    // Cooldown swallows eight exceeding lines; the ninth starts a fresh debounce.
    idle_cycle();
    cmp("lit_cooldown", longint'(state_o), 4);
    for (int i = 0; i < CDL; i++) begin
      line(1000, 0);
      cmp("lit_cd_no_fire", longint'(reflex_fire), 0);
    end
    cmp("lit_cd_done", longint'(state_o), 1);
    line(1000, 0);
    cmp("lit_t4_pending", longint'(state_o), 2);

    // A sub-threshold line (and the exact threshold) breaks the streak.
    line(150, 0);
    line(50, 0);
    cmp("lit_t2_back", longint'(state_o), 1);
    line(150, 0);
    line(100, 0);
    cmp("lit_equal_no_hit", longint'(state_o), 1);
    line(150, 0);
    line(150, 0);
    cmp("lit_t2_no_fire", longint'(reflex_fire), 0);

    // Dropping enable while two lines deep cancels the fire.
    step(1'b0, 1'b0, 1'b1, 150, 0);
    cmp("lit_t6_idle", longint'(state_o), 0);
    cmp("lit_t6_no_fire", longint'(reflex_fire), 0);
    idle_cycle();
    line(150, 0);
    line(150, 0);
    cmp("lit_t6_restart", longint'(state_o), 2);
    line(150, 0);
    cmp("lit_t6_fire", longint'(fire_count), 2);
    idle_cycle();

    // Asynchronous reset in the middle of cooldown.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    cmp("lit_async_state", longint'(state_o), 0);
    cmp("lit_async_count", longint'(fire_count), 0);
    cmp("lit_async_cmd", longint'(correction_cmd), 0);
    model_reset();
    step(1'b1, 1'b1, 1'b0, 0, 0);
    step(1'b0, 1'b1, 1'b0, 0, 0);

    // Jerk fires immediately with a negative drift.
    line(-4096, -300);
    cmp("lit_t3_fire", longint'(reflex_fire), 1);
    cmp("lit_t3_dir", longint'(reflex_dir), 0);
    cmp("lit_t3_cmd", longint'(correction_cmd), 64);
    idle_cycle();
    for (int i = 0; i < CDL; i++) line(0, 0);

    // Extreme drifts saturate the command at both ends.
    line(-(longint'(1) <<< (DW - 1)), -(longint'(1) <<< (DW - 1)));
    cmp("lit_t5_pos_sat", longint'(correction_cmd), 2047);
    idle_cycle();
    for (int i = 0; i < CDL; i++) line(0, 0);
    line((longint'(1) <<< (DW - 1)) - 1, (longint'(1) <<< (DW - 1)) - 1);
    cmp("lit_t5_neg_sat", longint'(correction_cmd), -2048);

    // Randomized traffic around the thresholds, with occasional extremes and resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 63) == 0) begin
        drift_thresh = DW'($urandom_range(0, 1000));
        jerk_thresh  = DW'($urandom_range(0, 2000));
      end
      span = longint'(drift_thresh) * 2 + 2;
      pick = $urandom_range(0, 9);
      if (pick == 0) d = longint'(drift_thresh);
      else if (pick == 1) d = -longint'(drift_thresh);
      else if (pick == 2) d = ($urandom_range(0, 1) == 1) ? -(longint'(1) <<< (DW - 1))
                                                         : (longint'(1) <<< (DW - 1)) - 1;
      else d = longint'($urandom_range(0, 2 * span)) - span;
      s = longint'($urandom_range(0, 4 * (jerk_thresh + 1))) - 2 * longint'(jerk_thresh + 1);
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 99) < 97),
           $urandom_range(0, 1), d, s);
    end

    // Frequent jerk fires drive the fire counter into saturation.
    jerk_thresh = DW'(0);
    for (int n = 0; n < 3200; n++) begin
      s = longint'($urandom_range(1, 500));
      d = longint'($urandom_range(0, 20000)) - 10000;
      step(1'b0, 1'b1, ($urandom_range(0, 3) != 0), d, s);
    end
    cmp("lit_count_sat", longint'(fire_count), 255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
